// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV32IC immediate generator: decode + extend to XLEN, then an elastic valid/ready pipe.
// Define RVC_EN to decode compressed (16-bit) encodings; otherwise they are flagged illegal.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
`ifdef RVC_EN
  localparam logic [2:0] FMT_C     = 3'd7;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_dec_illegal;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];

  // Extension to XLEN happens here once; the pipe only moves full-width words.
  always_comb begin
    w_dec_imm     = '0;
    w_dec_fmt     = FMT_NONE;
    w_dec_illegal = 1'b0;
    if (instr[1:0] == 2'b11) begin
      case (w_opcode)
        OP_LOAD, OP_JALR: begin
          w_dec_fmt = FMT_I;
          w_dec_imm = XLEN'($signed(instr[31:20]));
        end
        OP_IMM: begin
          if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
            w_dec_fmt = FMT_SHAMT;
            w_dec_imm = XLEN'(instr[24:20]);
          end else begin
            w_dec_fmt = FMT_I;
            w_dec_imm = XLEN'($signed(instr[31:20]));
          end
        end
        OP_STORE: begin
          w_dec_fmt = FMT_S;
          w_dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
        end
        OP_BRANCH: begin
          w_dec_fmt = FMT_B;
          w_dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        end
        OP_LUI, OP_AUIPC: begin
          w_dec_fmt = FMT_U;
          w_dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
        end
        OP_JAL: begin
          w_dec_fmt = FMT_J;
          w_dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        end
        default: begin
          w_dec_fmt = FMT_NONE;
        end
      endcase
    end else begin
`ifdef RVC_EN
      case (instr[1:0])
        2'b01: begin
          case (instr[15:13])
            3'b000, 3'b010: begin
              w_dec_fmt = FMT_C;
              w_dec_imm = XLEN'($signed({instr[12], instr[6:2]}));
            end
            3'b011: begin
              if (instr[11:7] != 5'd0 && instr[11:7] != 5'd2) begin
                w_dec_fmt = FMT_C;
                w_dec_imm = XLEN'($signed({instr[12], instr[6:2], 12'b0}));
              end
            end
            3'b101: begin
              w_dec_fmt = FMT_C;
              w_dec_imm = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                                         instr[2], instr[11], instr[5:3], 1'b0}));
            end
            3'b110, 3'b111: begin
              w_dec_fmt = FMT_C;
              w_dec_imm = XLEN'($signed({instr[12], instr[6:5], instr[2], instr[11:10],
                                         instr[4:3], 1'b0}));
            end
            default: begin
              w_dec_fmt = FMT_NONE;
            end
          endcase
        end
        2'b00: begin
          if (instr[15:13] == 3'b010 || instr[15:13] == 3'b110) begin
            w_dec_fmt = FMT_C;
            w_dec_imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
          end
        end
        default: begin
          w_dec_fmt = FMT_NONE;
        end
      endcase
`else
      w_dec_illegal = 1'b1;
`endif
    end
  end

  logic [STAGES-1:0] r_valid;
  logic [XLEN-1:0]   r_imm     [STAGES];
  logic [2:0]        r_fmt     [STAGES];
  logic              r_illegal [STAGES];

  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_up_valid;
  logic [XLEN-1:0]   w_up_imm     [STAGES];
  logic [2:0]        w_up_fmt     [STAGES];
  logic              w_up_illegal [STAGES];

  // Unrolled ready chain: a stage loads if it or any later stage has a hole, or the consumer takes.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_load[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!r_valid[j]) w_load[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_up_valid      = '0;
    w_up_valid[0]   = in_valid;
    w_up_imm[0]     = w_dec_imm;
    w_up_fmt[0]     = w_dec_fmt;
    w_up_illegal[0] = w_dec_illegal;
    for (int k = 1; k < STAGES; k++) begin
      w_up_valid[k]   = r_valid[k-1];
      w_up_imm[k]     = r_imm[k-1];
      w_up_fmt[k]     = r_fmt[k-1];
      w_up_illegal[k] = r_illegal[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_imm[k]     <= '0;
        r_fmt[k]     <= FMT_NONE;
        r_illegal[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_up_valid[k];
          if (w_up_valid[k]) begin
            r_imm[k]     <= w_up_imm[k];
            r_fmt[k]     <= w_up_fmt[k];
            r_illegal[k] <= w_up_illegal[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[STAGES-1];
  assign imm       = r_imm[STAGES-1];
  assign fmt       = r_fmt[STAGES-1];
  assign illegal   = r_illegal[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vectors, backpressure, mid-stream reset, random traffic.
module tb_imm_gen_pipe;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     instr = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;

  imm_gen_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  int   checks  = 0;
  int   errors  = 0;
  int   emitted = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int w);
    return 32'($signed(v << (32 - w)) >>> (32 - w));
  endfunction

  // Reference: immediate rebuilt bit by bit from its documented field placement.
  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    logic [31:0] off;
    e   = '0;
    off = '0;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h03, 7'h67: begin e.fmt = 3'd1; e.imm = sext(i >> 20, 12); end
        7'h13: begin
          if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
            e.fmt = 3'd6; e.imm = (i >> 20) & 32'h1F;
          end else begin
            e.fmt = 3'd1; e.imm = sext(i >> 20, 12);
          end
        end
        7'h23: begin
          e.fmt = 3'd2;
          e.imm = sext(((i >> 25) << 5) | ((i >> 7) & 32'h1F), 12);
        end
        7'h63: begin
          off[12] = i[31]; off[11] = i[7]; off[10:5] = i[30:25]; off[4:1] = i[11:8];
          e.fmt = 3'd3; e.imm = sext(off, 13);
        end
        7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = i & 32'hFFFF_F000; end
        7'h6F: begin
          off[20] = i[31]; off[19:12] = i[19:12]; off[11] = i[20]; off[10:1] = i[30:21];
          e.fmt = 3'd5; e.imm = sext(off, 21);
        end
        default: ;
      endcase
    end else begin
`ifdef RVC_EN
      if (i[1:0] == 2'b01) begin
        case (i[15:13])
          3'd0, 3'd2: begin e.fmt = 3'd7; e.imm = sext({26'b0, i[12], i[6:2]}, 6); end
          3'd3: if (i[11:7] != 5'd0 && i[11:7] != 5'd2) begin
            e.fmt = 3'd7; e.imm = sext({14'b0, i[12], i[6:2], 12'b0}, 18);
          end
          3'd5: begin
            off[11] = i[12]; off[4] = i[11]; off[9:8] = i[10:9]; off[10] = i[8];
            off[6] = i[7]; off[7] = i[6]; off[3:1] = i[5:3]; off[5] = i[2];
            e.fmt = 3'd7; e.imm = sext(off, 12);
          end
          3'd6, 3'd7: begin
            off[8] = i[12]; off[4:3] = i[11:10]; off[7:6] = i[6:5]; off[2:1] = i[4:3]; off[5] = i[2];
            e.fmt = 3'd7; e.imm = sext(off, 9);
          end
          default: ;
        endcase
      end else if (i[1:0] == 2'b00 && (i[15:13] == 3'd2 || i[15:13] == 3'd6)) begin
        off[6] = i[5]; off[5:3] = i[12:10]; off[2] = i[6];
        e.fmt = 3'd7; e.imm = off;
      end
`else
      e.ill = 1'b1;
`endif
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[6:0] = 7'h03;
      1: r[6:0] = 7'h67;
      2: r[6:0] = 7'h13;
      3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h37;
      6: r[6:0] = 7'h17;
      7: r[6:0] = 7'h6F;
      8: r[6:0] = 7'h33;
      default: r[1:0] = 2'($urandom_range(0, 2));
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input exp_t e);
    in_valid = v;
    instr    = ins;
    pend     = e;
  endtask

  // One clock: settle, score the handshakes that the coming edge performs, advance.
  task automatic step(output logic acc);
    exp_t e;
    logic emit;
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    chk("in_ready", 32'(in_ready), 32'((q.size() < STAGES) || out_ready));
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = q[0];
        chk(emit ? "imm" : "hold_imm", imm, e.imm);
        chk(emit ? "fmt" : "hold_fmt", 32'(fmt), 32'(e.fmt));
        chk(emit ? "illegal" : "hold_illegal", 32'(illegal), 32'(e.ill));
        if (emit) begin
          void'(q.pop_front());
          emitted++;
        end
      end
    end
    if (acc) q.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() > 0; n++) step(a);
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  logic [31:0] d_ins [6];
  logic [31:0] d_imm [6];
  logic [2:0]  d_fmt [6];
  logic        d_ill [6];

  function automatic exp_t dexp(input int k);
    exp_t e;
    e.imm = d_imm[k];
    e.fmt = d_fmt[k];
    e.ill = d_ill[k];
    return e;
  endfunction

  initial begin
    logic        a;
    int          n;
    int          base;
    logic [31:0] r;

    d_ins[0] = 32'hFFD00093; d_imm[0] = 32'hFFFFFFFD; d_fmt[0] = 3'd1; d_ill[0] = 1'b0;
    d_ins[1] = 32'hFE20AE23; d_imm[1] = 32'hFFFFFFFC; d_fmt[1] = 3'd2; d_ill[1] = 1'b0;
    d_ins[2] = 32'hFFDFF06F; d_imm[2] = 32'hFFFFFFFC; d_fmt[2] = 3'd5; d_ill[2] = 1'b0;
    d_ins[3] = 32'h41F0D093; d_imm[3] = 32'h0000001F; d_fmt[3] = 3'd6; d_ill[3] = 1'b0;
    d_ins[4] = 32'h800002B7; d_imm[4] = 32'h80000000; d_fmt[4] = 3'd4; d_ill[4] = 1'b0;
`ifdef RVC_EN
    d_ins[5] = 32'h000050FD; d_imm[5] = 32'hFFFFFFFF; d_fmt[5] = 3'd7; d_ill[5] = 1'b0;
`else
    d_ins[5] = 32'h000050FD; d_imm[5] = 32'h00000000; d_fmt[5] = 3'd0; d_ill[5] = 1'b1;
`endif

    // Reset held with a valid instruction presented.
    drive(1'b1, $urandom, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_fmt", 32'(fmt), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);

    drive(1'b1, d_ins[0], dexp(0));
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    step(a);
    chk("first_accept", 32'(a), 32'd1);
    drive(1'b0, '0, '0);
    for (int k = 1; k < STAGES; k++) begin
      chk("latency_early", 32'(out_valid), 32'd0);
      step(a);
    end
    chk("latency_due", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back directed stream at full throughput.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, d_ins[k], dexp(k));
      step(a);
      chk("b2b_accept", 32'(a), 32'd1);
      if (k >= STAGES - 1) chk("b2b_out_valid", 32'(out_valid), 32'd1);
    end
    drain();

    // Backpressure: five instructions, consumer stalled for four cycles.
    base = emitted;
    n = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, d_ins[1 + n], dexp(1 + n));
      step(a);
      if (a) n++;
    end
    chk("bp_stalled_count", 32'(n), 32'(STAGES));
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      drive(1'b1, d_ins[1 + n], dexp(1 + n));
      step(a);
      if (a) n++;
    end
    chk("bp_fed", 32'(n), 32'd5);
    drain();
    chk("bp_emitted", 32'(emitted - base), 32'd5);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      r = rnd_instr();
      drive(1'($urandom_range(0, 3) != 0), r, model(r));
      out_ready = ($urandom_range(0, 3) != 0);
      step(a);
    end
    drain();

    // Reset in the middle of a full pipe: contents are discarded.
    out_ready = 1'b0;
    for (int c = 0; c < STAGES + 1; c++) begin
      r = rnd_instr();
      drive(1'b1, r, model(r));
      step(a);
    end
    chk("pre_rst_full", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_imm", imm, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < STAGES + 3; c++) step(a);
    chk("post_rst_no_replay", 32'(out_valid), 32'd0);

    // Traffic resumes normally after the mid-stream reset.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, d_ins[k], dexp(k));
      step(a);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
